// File: rtl/crc_pkg.sv
// Shared types and helpers for the bit-serial CRC engine family.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_W = 64;

    // Bit-counter width for a word of n bits (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reverse the low w bits of v; bits at and above w come back zero.
    function automatic logic [MAX_W-1:0] rev(input logic [MAX_W-1:0] v, input int w);
        logic [MAX_W-1:0] r;
        logic [5:0]       idx;
        r = {MAX_W{1'b0}};
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) begin
                idx        = 6'(w - 1 - i);
                r[6'(i)]   = v[idx];
            end else begin
                r[6'(i)]   = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_stream_if.sv
// Word-in / CRC-out handshake bundle for crc_stream.
interface crc_stream_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 8,
    parameter int LEN_W  = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [CRC_W-1:0]  out_crc;
    logic [LEN_W-1:0]  out_len;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_crc, out_len, out_valid
    );

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_crc, out_len, out_valid
    );
endinterface

// File: rtl/crc_bit_step.sv
// One-bit LFSR update in normal (MSB-first) form; the x^CRC_W term is implicit.
module crc_bit_step #(
    parameter int               CRC_W = 8,
    parameter logic [CRC_W-1:0] POLY  = 8'h07
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             data_bit,
    output logic [CRC_W-1:0] crc_next
);
    logic fb_s;

    assign fb_s     = crc[CRC_W-1] ^ data_bit;
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (fb_s ? POLY : {CRC_W{1'b0}});
endmodule

// File: rtl/crc_stream.sv
// Bit-serial streaming CRC: accepts words over a handshake, shifts one bit per
// clock and presents the CRC plus a saturating word count when in_last completes.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               CRC_W       = 8,
    parameter int               DATA_W      = 8,
    parameter logic [CRC_W-1:0] POLY        = 8'h07,
    parameter logic [CRC_W-1:0] INIT        = {CRC_W{1'b0}},
    parameter logic [CRC_W-1:0] XOR_OUT     = {CRC_W{1'b0}},
    parameter bit               REFLECT_IN  = 1'b0,
    parameter bit               REFLECT_OUT = 1'b0,
    parameter int               LEN_W       = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    crc_stream_if.slave  bus
);
    localparam int CNT_W = cnt_width(DATA_W);

    state_t              state_r, state_s;
    logic [CRC_W-1:0]    crc_r, crc_s, crc_step_s, crc_rev_s;
    logic [DATA_W-1:0]   sh_r, sh_s, in_rev_s;
    logic                last_r, last_s;
    logic [LEN_W-1:0]    word_cnt_r, word_cnt_s;
    logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_s;
    logic [CRC_W-1:0]    out_crc_r, out_crc_s;
    logic [LEN_W-1:0]    out_len_r, out_len_s;
    logic                out_valid_r, out_valid_s;
    logic                in_ready_r, in_ready_s;

    crc_bit_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (
        .crc      (crc_r),
        .data_bit (sh_r[DATA_W-1]),
        .crc_next (crc_step_s)
    );

    assign in_rev_s  = DATA_W'(rev(64'(bus.in_data), DATA_W));
    assign crc_rev_s = CRC_W'(rev(64'(crc_step_s), CRC_W));

    // Next-state and datapath decode; clear overrides every other event.
    always_comb begin
        state_s     = state_r;
        crc_s       = crc_r;
        sh_s        = sh_r;
        last_s      = last_r;
        word_cnt_s  = word_cnt_r;
        bit_cnt_s   = bit_cnt_r;
        out_crc_s   = out_crc_r;
        out_len_s   = out_len_r;
        out_valid_s = out_valid_r;
        if (clear) begin
            state_s     = IDLE;
            crc_s       = INIT;
            word_cnt_s  = {LEN_W{1'b0}};
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        sh_s       = REFLECT_IN ? in_rev_s : bus.in_data;
                        last_s     = bus.in_last;
                        word_cnt_s = (word_cnt_r == {LEN_W{1'b1}}) ? word_cnt_r
                                                                   : word_cnt_r + 1'b1;
                        bit_cnt_s  = CNT_W'(DATA_W - 1);
                        state_s    = SHIFT;
                    end else begin
                        state_s    = IDLE;
                    end
                end
                SHIFT: begin
                    crc_s     = crc_step_s;
                    sh_s      = sh_r << 1;
                    bit_cnt_s = bit_cnt_r - 1'b1;
                    if (bit_cnt_r == {CNT_W{1'b0}}) begin
                        if (last_r) begin
                            out_crc_s   = (REFLECT_OUT ? crc_rev_s : crc_step_s) ^ XOR_OUT;
                            out_len_s   = word_cnt_r;
                            out_valid_s = 1'b1;
                            crc_s       = INIT;
                            word_cnt_s  = {LEN_W{1'b0}};
                            state_s     = DONE;
                        end else begin
                            state_s     = IDLE;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_s = 1'b0;
                        state_s     = IDLE;
                    end else begin
                        state_s     = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        in_ready_s = (state_s == IDLE);
    end

    // State and output registers; in_ready stays low until the first edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            crc_r       <= INIT;
            sh_r        <= {DATA_W{1'b0}};
            last_r      <= 1'b0;
            word_cnt_r  <= {LEN_W{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            out_crc_r   <= {CRC_W{1'b0}};
            out_len_r   <= {LEN_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            crc_r       <= crc_s;
            sh_r        <= sh_s;
            last_r      <= last_s;
            word_cnt_r  <= word_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            out_crc_r   <= out_crc_s;
            out_len_r   <= out_len_s;
            out_valid_r <= out_valid_s;
            in_ready_r  <= in_ready_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_crc   = out_crc_r;
    assign bus.out_len   = out_len_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_crc_stream.sv
// Four crc_stream configurations driven in lockstep from one stimulus stream.
module tb_crc_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    always #5 clk = ~clk;

    crc_stream_if #(.DATA_W(8), .CRC_W(8),  .LEN_W(16)) ia ();
    crc_stream_if #(.DATA_W(8), .CRC_W(16), .LEN_W(16)) ib ();
    crc_stream_if #(.DATA_W(8), .CRC_W(8),  .LEN_W(16)) ic ();
    crc_stream_if #(.DATA_W(8), .CRC_W(8),  .LEN_W(2))  id ();

    assign ia.in_data = in_data;  assign ia.in_last = in_last;
    assign ia.in_valid = in_valid; assign ia.out_ready = out_ready;
    assign ib.in_data = in_data;  assign ib.in_last = in_last;
    assign ib.in_valid = in_valid; assign ib.out_ready = out_ready;
    assign ic.in_data = in_data;  assign ic.in_last = in_last;
    assign ic.in_valid = in_valid; assign ic.out_ready = out_ready;
    assign id.in_data = in_data;  assign id.in_last = in_last;
    assign id.in_valid = in_valid; assign id.out_ready = out_ready;

    crc_stream #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00)) u_a (
        .clk(clk), .rst(rst), .clear(clear), .bus(ia));
    crc_stream #(.CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF)) u_b (
        .clk(clk), .rst(rst), .clear(clear), .bus(ib));
    crc_stream #(.CRC_W(8), .DATA_W(8), .POLY(8'h31), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u_c (
        .clk(clk), .rst(rst), .clear(clear), .bus(ic));
    crc_stream #(.CRC_W(8), .DATA_W(8), .POLY(8'h07), .LEN_W(2)) u_d (
        .clk(clk), .rst(rst), .clear(clear), .bus(id));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ia.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(ia.in_ready), 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (ia.out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_wait", 32'(ia.out_valid), 32'd1);
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        wait_ready();
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg();
        for (int i = 0; i < 9; i++) send_word(msg[i], i == 8);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        rst = 1'b1; clear = 1'b0; in_data = 8'h00; in_last = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_in_ready",  32'(ia.in_ready),  32'd0);
        check("rst_out_valid", 32'(ia.out_valid), 32'd0);
        check("rst_out_crc",   32'(ia.out_crc),   32'd0);
        check("rst_out_len",   32'(ia.out_len),   32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(ia.in_ready), 32'd1);

        // Single word 0x41 with latency check.
        send_word(8'h41, 1'b1);
        repeat (7) tick();
        check("lat_before", 32'(ia.out_valid), 32'd0);
        tick();
        check("lat_at_n8",  32'(ia.out_valid), 32'd1);
        check("crc8_41",    32'(ia.out_crc),   32'h0000_00C0);
        check("len_41",     32'(ia.out_len),   32'd1);
        check("len_41_sat", 32'(id.out_len),   32'd1);
        drain();
        check("drain_valid", 32'(ia.out_valid), 32'd0);

        // Check string across all four configurations.
        send_msg();
        wait_valid();
        check("crc8_check",  32'(ia.out_crc), 32'h0000_00F4);
        check("len_check",   32'(ia.out_len), 32'd9);
        check("ccitt_check", 32'(ib.out_crc), 32'h0000_29B1);
        check("maxim_check", 32'(ic.out_crc), 32'h0000_00A1);
        check("sat_crc",     32'(id.out_crc), 32'h0000_00F4);
        check("sat_len",     32'(id.out_len), 32'd3);

        // Backpressure: result held, waiting word not consumed.
        in_data = 8'h55; in_last = 1'b1; in_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ia.out_crc !== 8'hF4 || ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1) stable = 1'b0;
        end
        check("hold_stable",   32'(stable),       32'd1);
        check("hold_in_ready", 32'(ia.in_ready),  32'd0);
        check("hold_len",      32'(ia.out_len),   32'd9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_valid", 32'(ia.out_valid), 32'd0);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_valid();
        check("next_from_init_crc", 32'(ia.out_crc), 32'h0000_00AC);
        check("next_from_init_len", 32'(ia.out_len), 32'd1);
        drain();

        // Clear in the middle of word 3, then resend the whole message.
        send_word(msg[0], 1'b0);
        send_word(msg[1], 1'b0);
        send_word(msg[2], 1'b0);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_in_ready",  32'(ia.in_ready),  32'd1);
        check("clear_out_valid", 32'(ia.out_valid), 32'd0);
        check("clear_keep_crc",  32'(ia.out_crc),   32'h0000_00AC);
        send_msg();
        wait_valid();
        check("after_clear_crc", 32'(ia.out_crc), 32'h0000_00F4);
        check("after_clear_len", 32'(ia.out_len), 32'd9);
        drain();

        // Clear together with an offered word in IDLE: word must be dropped.
        wait_ready();
        clear = 1'b1; in_data = 8'h41; in_last = 1'b1; in_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        check("clear_accept_ready", 32'(ia.in_ready), 32'd1);
        repeat (10) tick();
        check("clear_accept_valid", 32'(ia.out_valid), 32'd0);

        // Asynchronous reset while in DONE.
        send_word(8'h41, 1'b1);
        wait_valid();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid",    32'(ia.out_valid), 32'd0);
        check("async_rst_crc",      32'(ia.out_crc),   32'd0);
        check("async_rst_len",      32'(ia.out_len),   32'd0);
        check("async_rst_in_ready", 32'(ia.in_ready),  32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("async_rel_in_ready", 32'(ia.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
Parametrised bit-serial CRC engine for streamed messages.
- Accepts DATA_W-bit words over a valid/ready handshake and processes one bit per clock.
- Presents the final CRC over a second valid/ready handshake when the word flagged in_last has been processed.
- Generalises the fixed 8-bit, single-word CRC blocks to any width, polynomial, init value, output XOR and reflection mode, with multi-word messages and a word counter.

Parameters:
- CRC_W, 8, CRC width in bits (2..32).
- DATA_W, 8, input word width in bits (1..64).
- POLY, 8'h07, generator polynomial in normal form; the x^CRC_W term is implicit. Width CRC_W.
- INIT, 0, CRC register value at message start. Width CRC_W.
- XOR_OUT, 0, value XORed into the final CRC. Width CRC_W.
- REFLECT_IN, 0, 1 = bit-reverse each input word before shifting (LSB first).
- REFLECT_OUT, 0, 1 = bit-reverse the CRC before XOR_OUT.
- LEN_W, 16, width of the message word counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort: drop the message and any pending result.
- in_data  in  DATA_W  message word.
- in_last  in  1  marks the final word of a message.
- in_valid  in  1  in_data/in_last are valid.
- in_ready  out  1  engine can accept a word this cycle.
- out_crc  out  CRC_W  final CRC of the completed message.
- out_len  out  LEN_W  number of words in the completed message, saturating.
- out_valid  out  1  out_crc/out_len are valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, crc_reg=INIT, word_cnt=0, bit_cnt=0.
  - in_ready=0 while rst is high, then 1 from the first cycle after release.
  - out_valid=0, out_crc=0, out_len=0.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch sh_reg = REFLECT_IN ? rev(in_data) : in_data, and latch last_q=in_last.
  - Increment word_cnt, saturating at all-ones.
  - Set bit_cnt=DATA_W-1 and go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: fb = crc_reg[CRC_W-1] ^ sh_reg[DATA_W-1]; crc_reg = (crc_reg<<1) ^ (fb ? POLY : 0); sh_reg <<= 1; bit_cnt decrements.
  - The cycle that processes bit_cnt==0:
    - If last_q: out_crc = (REFLECT_OUT ? rev(crc_next) : crc_next) ^ XOR_OUT; out_len=word_cnt; crc_reg=INIT; word_cnt=0; go to DONE.
    - Otherwise go to IDLE with crc_reg kept.
- DONE:
  - out_valid=1; out_crc/out_len held stable; in_ready=0.
  - On out_ready: out_valid=0 on the next edge and go to IDLE.
- Latency and throughput:
  - A word accepted at edge N finishes shifting at edge N+DATA_W.
  - For a last word, out_valid is high from edge N+DATA_W.
  - Throughput is one word per DATA_W+1 cycles.
- clear:
  - Takes priority over every other event in the same cycle, including an in_valid accept or out_ready.
  - Next state is IDLE; crc_reg=INIT, word_cnt=0, out_valid=0; out_crc/out_len keep their last values.
- Backpressure: in_valid may stay high while in_ready=0. The word is not consumed and data must be held by the source.
- word_cnt saturation: stays at 2^LEN_W-1 and the CRC keeps computing correctly.
- Reset mid-SHIFT or in DONE: all state and outputs return to reset values immediately; the partial message is lost.
- Single-word messages (in_last on the first word) are legal.
- in_valid with X data while in_ready=0 must not disturb state.

Decomposition:
- Package crc_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Generic bit-reverse function rev() used for both in and out reflection.
  - Localparam CNT_W = clog2(DATA_W).
- Sub-module crc_bit_step: combinational single-bit LFSR update, parametrised by CRC_W and POLY. Inputs are crc and data bit; output is crc_next. It is reused by future parallel variants.
- The FSM, counters and handshakes stay in crc_stream.

Test Plan:
- CRC_W=8, POLY=0x07, INIT=0: single word 0x41 with in_last → out_crc=0xC0, out_len=1, out_valid at edge accept+8.
- Same config, "123456789" (0x31..0x39) as 9 words, last on 0x39 → out_crc=0xF4, out_len=9.
- CRC_W=16, POLY=0x1021, INIT=0xFFFF → out_crc=0x29B1 for "123456789". REFLECT_IN=REFLECT_OUT=1, POLY=0x31, CRC_W=8 → out_crc=0xA1.
- out_ready held low for 20 cycles after out_valid → out_crc stable, in_ready=0, a waiting in_valid is not consumed. Then raise out_ready → next message starts from INIT.
- Assert clear mid-SHIFT of word 3 of "123456789", then resend the full message → out_crc=0xF4, out_len=9. Assert clear together with in_valid in IDLE → word not accepted.
- Assert rst asynchronously (between edges) in DONE → out_valid=0 immediately. LEN_W=2 with a 5-word message → out_len=3 (saturated) and the CRC is still correct.
